// File: rtl/hazard_if.sv
// ============================================================================
// Module      : hazard_if
// Description : Pipeline-field and stage-control bundle for the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] ifid_registerA;
    logic [REG_ADDR_W-1:0] ifid_registerB;
    logic                  ifid_readA;
    logic                  ifid_readB;
    logic [REG_ADDR_W-1:0] idex_registerA;
    logic [REG_ADDR_W-1:0] idex_registerB;
    logic [REG_ADDR_W-1:0] idex_registerFileWrite;
    logic                  idex_memRead;
    logic                  idex_regWrite;
    logic                  idex_branch;
    logic                  branchTaken;
    logic                  idex_jumpRegister;
    logic [REG_ADDR_W-1:0] exmem_registerFileWrite;
    logic                  exmem_regWrite;
    logic [REG_ADDR_W-1:0] memwb_registerFileWrite;
    logic                  memwb_regWrite;
    logic                  pcWrite;
    logic                  ifidWrite;
    logic                  ifidFlush;
    logic                  idexBubble;
    logic [1:0]            forwardA;
    logic [1:0]            forwardB;
    logic [CNT_W-1:0]      loadUseStalls;
    logic [CNT_W-1:0]      flushCount;

    // Pipeline side: presents stage fields, receives control.
    modport master (
        output ifid_registerA, ifid_registerB, ifid_readA, ifid_readB,
        output idex_registerA, idex_registerB, idex_registerFileWrite,
        output idex_memRead, idex_regWrite, idex_branch, branchTaken, idex_jumpRegister,
        output exmem_registerFileWrite, exmem_regWrite,
        output memwb_registerFileWrite, memwb_regWrite,
        input  pcWrite, ifidWrite, ifidFlush, idexBubble,
        input  forwardA, forwardB, loadUseStalls, flushCount
    );

    // Hazard unit side.
    modport slave (
        input  ifid_registerA, ifid_registerB, ifid_readA, ifid_readB,
        input  idex_registerA, idex_registerB, idex_registerFileWrite,
        input  idex_memRead, idex_regWrite, idex_branch, branchTaken, idex_jumpRegister,
        input  exmem_registerFileWrite, exmem_regWrite,
        input  memwb_registerFileWrite, memwb_regWrite,
        output pcWrite, ifidWrite, ifidFlush, idexBubble,
        output forwardA, forwardB, loadUseStalls, flushCount
    );
endinterface

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module      : hazard_unit
// Description : Load-use stall, branch/jumpRegister flush, EX forwarding and
//               saturating stall/flush counters for the ID/EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit #(
    parameter int REG_ADDR_W          = 4,
    parameter int LOAD_STALL_CYCLES   = 1,
    parameter int BRANCH_FLUSH_CYCLES = 1,
    parameter int CNT_W               = 16
) (
    input  wire logic clock,
    input  wire logic reset,
    hazard_if.slave   hz
);

    localparam int MAX_CYC = (LOAD_STALL_CYCLES > BRANCH_FLUSH_CYCLES) ?
                             LOAD_STALL_CYCLES : BRANCH_FLUSH_CYCLES;
    localparam int SEQ_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [SEQ_W-1:0] c_seq_one    = SEQ_W'(1);
    localparam logic [SEQ_W-1:0] c_seq_zero   = SEQ_W'(0);
    localparam logic [SEQ_W-1:0] c_load_reld  = SEQ_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [SEQ_W-1:0] c_flush_reld = SEQ_W'(BRANCH_FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
    localparam logic [REG_ADDR_W-1:0] c_reg_zero = '0;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2
    } state_t;

    state_t           r_state, w_next_state;
    logic [SEQ_W-1:0] r_cnt, w_next_cnt;
    logic [CNT_W-1:0] r_load_stalls, r_flush_count;

    logic w_redirect, w_load_use, w_inc_stall, w_inc_flush;
    logic w_pc_write, w_ifid_write, w_ifid_flush, w_idex_bubble;
    logic [1:0] w_fwd_a, w_fwd_b;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] exmem_rd,
        input logic                  exmem_we,
        input logic [REG_ADDR_W-1:0] memwb_rd,
        input logic                  memwb_we
    );
        if (exmem_we && exmem_rd != c_reg_zero && exmem_rd == src)
            return 2'b10;
        else if (memwb_we && memwb_rd != c_reg_zero && memwb_rd == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_redirect = (hz.idex_branch & hz.branchTaken) | hz.idex_jumpRegister;

    assign w_load_use = hz.idex_memRead & hz.idex_regWrite &
                        (hz.idex_registerFileWrite != c_reg_zero) &
                        ((hz.ifid_readA & (hz.ifid_registerA == hz.idex_registerFileWrite)) |
                         (hz.ifid_readB & (hz.ifid_registerB == hz.idex_registerFileWrite)));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_cnt         <= c_seq_zero;
            r_load_stalls <= '0;
            r_flush_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_inc_stall && r_load_stalls != {CNT_W{1'b1}})
                r_load_stalls <= r_load_stalls + c_cnt_one;
            if (w_inc_flush && r_flush_count != {CNT_W{1'b1}})
                r_flush_count <= r_flush_count + c_cnt_one;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_inc_stall   = 1'b0;
        w_inc_flush   = 1'b0;

        if (r_state == ST_FLUSH) begin
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
            w_next_cnt    = r_cnt - c_seq_one;
            if (r_cnt == c_seq_one)
                w_next_state = ST_RUN;
        end else if (w_redirect) begin
            // Redirect wins over any pending stall: the stalled instruction is on the wrong path.
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
            w_inc_flush   = 1'b1;
            if (BRANCH_FLUSH_CYCLES > 1) begin
                w_next_state = ST_FLUSH;
                w_next_cnt   = c_flush_reld;
            end else begin
                w_next_state = ST_RUN;
                w_next_cnt   = c_seq_zero;
            end
        end else if (r_state == ST_LOAD_STALL) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
            w_inc_stall   = 1'b1;
            w_next_cnt    = r_cnt - c_seq_one;
            if (r_cnt == c_seq_one)
                w_next_state = ST_RUN;
        end else if (r_state == ST_RUN && w_load_use) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
            w_inc_stall   = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                w_next_state = ST_LOAD_STALL;
                w_next_cnt   = c_load_reld;
            end
        end else if (r_state != ST_RUN) begin
            w_next_state = ST_RUN;
        end

        w_fwd_a = fwd_sel(hz.idex_registerA, hz.exmem_registerFileWrite, hz.exmem_regWrite,
                          hz.memwb_registerFileWrite, hz.memwb_regWrite);
        w_fwd_b = fwd_sel(hz.idex_registerB, hz.exmem_registerFileWrite, hz.exmem_regWrite,
                          hz.memwb_registerFileWrite, hz.memwb_regWrite);

        // Reset holds the front end frozen and the EX stage bubbled.
        if (reset) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
            w_fwd_a       = 2'b00;
            w_fwd_b       = 2'b00;
        end
    end

    assign hz.pcWrite       = w_pc_write;
    assign hz.ifidWrite     = w_ifid_write;
    assign hz.ifidFlush     = w_ifid_flush;
    assign hz.idexBubble    = w_idex_bubble;
    assign hz.forwardA      = w_fwd_a;
    assign hz.forwardB      = w_fwd_b;
    assign hz.loadUseStalls = r_load_stalls;
    assign hz.flushCount    = r_flush_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit, two parameterisations
//               driven with identical stimulus against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_unit;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    hazard_if #(.REG_ADDR_W(4), .CNT_W(16)) bus0 ();
    hazard_if #(.REG_ADDR_W(4), .CNT_W(2))  bus1 ();

    assign bus1.ifid_registerA          = bus0.ifid_registerA;
    assign bus1.ifid_registerB          = bus0.ifid_registerB;
    assign bus1.ifid_readA              = bus0.ifid_readA;
    assign bus1.ifid_readB              = bus0.ifid_readB;
    assign bus1.idex_registerA          = bus0.idex_registerA;
    assign bus1.idex_registerB          = bus0.idex_registerB;
    assign bus1.idex_registerFileWrite  = bus0.idex_registerFileWrite;
    assign bus1.idex_memRead            = bus0.idex_memRead;
    assign bus1.idex_regWrite           = bus0.idex_regWrite;
    assign bus1.idex_branch             = bus0.idex_branch;
    assign bus1.branchTaken             = bus0.branchTaken;
    assign bus1.idex_jumpRegister       = bus0.idex_jumpRegister;
    assign bus1.exmem_registerFileWrite = bus0.exmem_registerFileWrite;
    assign bus1.exmem_regWrite          = bus0.exmem_regWrite;
    assign bus1.memwb_registerFileWrite = bus0.memwb_registerFileWrite;
    assign bus1.memwb_regWrite          = bus0.memwb_regWrite;

    hazard_unit #(.REG_ADDR_W(4), .LOAD_STALL_CYCLES(1), .BRANCH_FLUSH_CYCLES(1), .CNT_W(16)) dut0 (
        .clock (clock),
        .reset (reset),
        .hz    (bus0)
    );

    hazard_unit #(.REG_ADDR_W(4), .LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(2), .CNT_W(2)) dut1 (
        .clock (clock),
        .reset (reset),
        .hz    (bus1)
    );

    // Outputs of both instances gathered as {pcWrite, ifidWrite, ifidFlush, idexBubble}.
    logic [3:0]  act_ctl [2];
    logic [1:0]  act_fa  [2];
    logic [1:0]  act_fb  [2];
    logic [15:0] act_lus [2];
    logic [15:0] act_fc  [2];

    assign act_ctl[0] = {bus0.pcWrite, bus0.ifidWrite, bus0.ifidFlush, bus0.idexBubble};
    assign act_ctl[1] = {bus1.pcWrite, bus1.ifidWrite, bus1.ifidFlush, bus1.idexBubble};
    assign act_fa[0]  = bus0.forwardA;
    assign act_fa[1]  = bus1.forwardA;
    assign act_fb[0]  = bus0.forwardB;
    assign act_fb[1]  = bus1.forwardB;
    assign act_lus[0] = bus0.loadUseStalls;
    assign act_lus[1] = {14'd0, bus1.loadUseStalls};
    assign act_fc[0]  = bus0.flushCount;
    assign act_fc[1]  = {14'd0, bus1.flushCount};

    localparam int LSC  [2] = '{1, 3};
    localparam int BFC  [2] = '{1, 2};
    localparam int MAXC [2] = '{65535, 3};

    // Model: remaining stall/bubble cycles owed, plus the event tallies.
    int m_stall [2] = '{0, 0};
    int m_flush [2] = '{0, 0};
    int m_lus   [2] = '{0, 0};
    int m_fc    [2] = '{0, 0};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int fwd_model(input int src);
        if (bus0.exmem_regWrite && bus0.exmem_registerFileWrite != 0 &&
            int'(bus0.exmem_registerFileWrite) == src) return 2;
        if (bus0.memwb_regWrite && bus0.memwb_registerFileWrite != 0 &&
            int'(bus0.memwb_registerFileWrite) == src) return 1;
        return 0;
    endfunction

    initial begin
        forever begin
            @(negedge clock);
            if (cmp_en) begin
                for (int i = 0; i < 2; i++) begin
                    bit redirect, lu;
                    int e_ctl, e_fa, e_fb;
                    redirect = (bus0.idex_branch && bus0.branchTaken) || bus0.idex_jumpRegister;
                    lu = bus0.idex_memRead && bus0.idex_regWrite && bus0.idex_registerFileWrite != 0 &&
                         ((bus0.ifid_readA && bus0.ifid_registerA == bus0.idex_registerFileWrite) ||
                          (bus0.ifid_readB && bus0.ifid_registerB == bus0.idex_registerFileWrite));
                    e_fa = reset ? 0 : fwd_model(int'(bus0.idex_registerA));
                    e_fb = reset ? 0 : fwd_model(int'(bus0.idex_registerB));
                    if (reset)                      e_ctl = 4'b0011;
                    else if (m_flush[i] > 0)        e_ctl = 4'b1111;
                    else if (redirect)              e_ctl = 4'b1111;
                    else if (m_stall[i] > 0 || lu)  e_ctl = 4'b0001;
                    else                            e_ctl = 4'b1100;
                    check($sformatf("dut%0d ctl", i), int'(act_ctl[i]), e_ctl);
                    check($sformatf("dut%0d forwardA", i), int'(act_fa[i]), e_fa);
                    check($sformatf("dut%0d forwardB", i), int'(act_fb[i]), e_fb);
                    check($sformatf("dut%0d loadUseStalls", i), int'(act_lus[i]), m_lus[i]);
                    check($sformatf("dut%0d flushCount", i), int'(act_fc[i]), m_fc[i]);
                    if (reset) begin
                        m_stall[i] = 0; m_flush[i] = 0; m_lus[i] = 0; m_fc[i] = 0;
                    end else if (m_flush[i] > 0) begin
                        m_flush[i]--;
                    end else if (redirect) begin
                        if (m_fc[i] < MAXC[i]) m_fc[i]++;
                        m_flush[i] = BFC[i] - 1;
                        m_stall[i] = 0;
                    end else if (m_stall[i] > 0 || lu) begin
                        if (m_lus[i] < MAXC[i]) m_lus[i]++;
                        m_stall[i] = (m_stall[i] > 0) ? m_stall[i] - 1 : LSC[i] - 1;
                    end
                end
            end
        end
    end

    task automatic idle();
        bus0.ifid_registerA = 0; bus0.ifid_registerB = 0;
        bus0.ifid_readA = 0; bus0.ifid_readB = 0;
        bus0.idex_registerA = 0; bus0.idex_registerB = 0; bus0.idex_registerFileWrite = 0;
        bus0.idex_memRead = 0; bus0.idex_regWrite = 0;
        bus0.idex_branch = 0; bus0.branchTaken = 0; bus0.idex_jumpRegister = 0;
        bus0.exmem_registerFileWrite = 0; bus0.exmem_regWrite = 0;
        bus0.memwb_registerFileWrite = 0; bus0.memwb_regWrite = 0;
    endtask

    task automatic load_use_r3();
        bus0.idex_memRead = 1; bus0.idex_regWrite = 1; bus0.idex_registerFileWrite = 3;
        bus0.ifid_readA = 1; bus0.ifid_registerA = 3;
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // T1: reset with a would-be forwarding match present
        reset = 1'b1;
        idle();
        bus0.exmem_regWrite = 1; bus0.exmem_registerFileWrite = 2; bus0.idex_registerA = 2;
        cmp_en = 1'b1;
        @(negedge clock);
        check("T1 reset pcWrite", int'(bus0.pcWrite), 0);
        check("T1 reset idexBubble", int'(bus0.idexBubble), 1);
        check("T1 reset forwardA", int'(bus0.forwardA), 0);
        check("T1 reset loadUseStalls", int'(bus0.loadUseStalls), 0);
        check("T1 reset flushCount", int'(bus0.flushCount), 0);
        nxt();
        nxt();
        reset = 1'b0;
        @(negedge clock);
        check("T1 run pcWrite", int'(bus0.pcWrite), 1);
        check("T1 run ifidFlush", int'(bus0.ifidFlush), 0);
        check("T1 run forwardA", int'(bus0.forwardA), 2);

        // T2: single-cycle load-use stall
        nxt(); idle(); load_use_r3();
        @(negedge clock);
        check("T2 stall pcWrite", int'(bus0.pcWrite), 0);
        check("T2 stall idexBubble", int'(bus0.idexBubble), 1);
        check("T2 stall ifidFlush", int'(bus0.ifidFlush), 0);
        nxt(); idle();
        @(negedge clock);
        check("T2 after pcWrite", int'(bus0.pcWrite), 1);
        check("T2 loadUseStalls", int'(bus0.loadUseStalls), 1);
        check("T2 dut1 still stalled", int'(bus1.pcWrite), 0);
        nxt(); nxt(); nxt();

        // T3: rd = 0, then readA = 0 -> no stall
        load_use_r3(); bus0.idex_registerFileWrite = 0; bus0.ifid_registerA = 0;
        @(negedge clock);
        check("T3 rd0 pcWrite", int'(bus0.pcWrite), 1);
        check("T3 rd0 dut1 pcWrite", int'(bus1.pcWrite), 1);
        nxt(); idle(); load_use_r3(); bus0.ifid_readA = 0;
        @(negedge clock);
        check("T3 noread pcWrite", int'(bus0.pcWrite), 1);
        check("T3 noread idexBubble", int'(bus1.idexBubble), 0);
        nxt(); idle();
        @(negedge clock);
        check("T3 loadUseStalls", int'(bus0.loadUseStalls), 1);

        // T4: load-use and taken branch together
        nxt(); reset = 1'b1;
        nxt(); reset = 1'b0; load_use_r3(); bus0.idex_branch = 1; bus0.branchTaken = 1;
        @(negedge clock);
        check("T4 c1 dut1 ifidFlush", int'(bus1.ifidFlush), 1);
        check("T4 c1 dut1 pcWrite", int'(bus1.pcWrite), 1);
        nxt(); idle();
        @(negedge clock);
        check("T4 c2 dut1 ifidFlush", int'(bus1.ifidFlush), 1);
        check("T4 c2 dut1 idexBubble", int'(bus1.idexBubble), 1);
        check("T4 c2 dut0 ifidFlush", int'(bus0.ifidFlush), 0);
        nxt();
        @(negedge clock);
        check("T4 c3 dut1 ifidFlush", int'(bus1.ifidFlush), 0);
        check("T4 dut1 flushCount", int'(bus1.flushCount), 1);
        check("T4 dut1 loadUseStalls", int'(bus1.loadUseStalls), 0);

        // T5: forwarding priority
        nxt();
        bus0.exmem_regWrite = 1; bus0.exmem_registerFileWrite = 5;
        bus0.memwb_regWrite = 1; bus0.memwb_registerFileWrite = 5;
        bus0.idex_registerB = 5; bus0.idex_registerA = 6;
        @(negedge clock);
        check("T5 forwardB exmem", int'(bus0.forwardB), 2);
        check("T5 forwardA none", int'(bus0.forwardA), 0);
        nxt(); bus0.exmem_regWrite = 0;
        @(negedge clock);
        check("T5 forwardB memwb", int'(bus0.forwardB), 1);

        // T6: reset mid-stall, then counter saturation
        nxt(); idle(); load_use_r3();
        nxt(); idle(); reset = 1'b1;
        @(negedge clock);
        check("T6 reset dut1 pcWrite", int'(bus1.pcWrite), 0);
        nxt(); reset = 1'b0;
        @(negedge clock);
        check("T6 run dut1 pcWrite", int'(bus1.pcWrite), 1);
        check("T6 run dut1 idexBubble", int'(bus1.idexBubble), 0);
        for (int k = 0; k < 5; k++) begin
            nxt(); load_use_r3();
        end
        nxt(); idle();
        @(negedge clock);
        check("T6 dut1 loadUseStalls saturated", int'(bus1.loadUseStalls), 3);
        check("T6 dut0 loadUseStalls", int'(bus0.loadUseStalls), 5);

        // Mixed vectors from a small register range so hazards and matches are frequent
        for (int k = 0; k < 300; k++) begin
            nxt();
            reset = ($urandom_range(0, 15) == 0);
            bus0.ifid_registerA = 4'($urandom_range(0, 3));
            bus0.ifid_registerB = 4'($urandom_range(0, 3));
            bus0.ifid_readA = 1'($urandom_range(0, 1));
            bus0.ifid_readB = 1'($urandom_range(0, 1));
            bus0.idex_registerA = 4'($urandom_range(0, 3));
            bus0.idex_registerB = 4'($urandom_range(0, 3));
            bus0.idex_registerFileWrite = 4'($urandom_range(0, 3));
            bus0.idex_memRead = 1'($urandom_range(0, 1));
            bus0.idex_regWrite = 1'($urandom_range(0, 1));
            bus0.idex_branch = ($urandom_range(0, 3) == 0);
            bus0.branchTaken = 1'($urandom_range(0, 1));
            bus0.idex_jumpRegister = ($urandom_range(0, 9) == 0);
            bus0.exmem_registerFileWrite = 4'($urandom_range(0, 3));
            bus0.exmem_regWrite = 1'($urandom_range(0, 1));
            bus0.memwb_registerFileWrite = 4'($urandom_range(0, 3));
            bus0.memwb_regWrite = 1'($urandom_range(0, 1));
        end
        @(negedge clock);
        #1;
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
